ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter_pkg.sv | 23 ++
 rtl/ram_arbiter_arb_rr2.sv | 39 +++
 rtl/ram_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared CPU bus definitions for the RAM arbiter: default bus widths and the
// requester identity used by the round-robin logic.
package ram_arbiter_pkg;

  localparam int CPU_ADDR_WIDTH = 8;
  localparam int CPU_DATA_WIDTH = 16;

  typedef enum logic {
    REQ_CPU    = 1'b0,
    REQ_LOADER = 1'b1
  } req_id_e;

  function automatic logic [1:0] grant_onehot(input req_id_e id);
    logic [1:0] onehot;
    if (id == REQ_LOADER) begin
      onehot = 2'b10;
    end else begin
      onehot = 2'b01;
    end
    return onehot;
  endfunction

endpackage

// File: rtl/ram_arbiter_arb_rr2.sv
// Two-way round-robin winner selection; the pointer remembers the last grant
// and only moves when a grant is actually taken.
module arb_rr2
  import ram_arbiter_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    req0,
  input  logic    req1,
  input  logic    grant,
  output req_id_e winner
);

  req_id_e last_r;

  // Contended requests go to whichever side did not win last time.
  always_comb begin
    winner = REQ_CPU;
    if (req0 && req1) begin
      winner = (last_r == REQ_CPU) ? REQ_LOADER : REQ_CPU;
    end else if (req1) begin
      winner = REQ_LOADER;
    end else begin
      winner = REQ_CPU;
    end
  end

  // Resetting to "loader granted last" lets the CPU win the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_r <= REQ_LOADER;
    end else if (grant) begin
      last_r <= winner;
    end else begin
      last_r <= last_r;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates a CPU data port and a loader/debug port onto one single-port RAM
// with a one-cycle synchronous read.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = CPU_ADDR_WIDTH,
  parameter int DATA_WIDTH = CPU_DATA_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_req0,
  input  logic                  i_req1,
  input  logic                  i_we0,
  input  logic                  i_we1,
  input  logic [ADDR_WIDTH-1:0] i_addr0,
  input  logic [ADDR_WIDTH-1:0] i_addr1,
  input  logic [DATA_WIDTH-1:0] i_wdata0,
  input  logic [DATA_WIDTH-1:0] i_wdata1,
  output logic                  o_ack0,
  output logic                  o_ack1,
  output logic                  o_rvalid0,
  output logic                  o_rvalid1,
  output logic [DATA_WIDTH-1:0] o_rdata0,
  output logic [DATA_WIDTH-1:0] o_rdata1,
  output logic                  o_ram_load,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_data,
  input  logic [DATA_WIDTH-1:0] i_ram_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RDATA = 2'd2
  } state_e;

  state_e                state_r;
  state_e                state_next_s;
  req_id_e               winner_s;
  req_id_e               winner_r;
  logic                  grant_s;
  logic                  sel_we_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [DATA_WIDTH-1:0] sel_wdata_s;
  logic [1:0]            ack_r;
  logic [1:0]            rvalid_r;
  logic                  load_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] data_r;
  logic [DATA_WIDTH-1:0] rdata0_r;
  logic [DATA_WIDTH-1:0] rdata1_r;

  assign grant_s = (state_r == IDLE) && (i_req0 || i_req1);

  arb_rr2 u_arb (
    .clk    (i_clk),
    .rst    (i_reset),
    .req0   (i_req0),
    .req1   (i_req1),
    .grant  (grant_s),
    .winner (winner_s)
  );

  // Steer the winning requester's fields toward the capture registers.
  always_comb begin
    sel_we_s    = i_we0;
    sel_addr_s  = i_addr0;
    sel_wdata_s = i_wdata0;
    if (winner_s == REQ_LOADER) begin
      sel_we_s    = i_we1;
      sel_addr_s  = i_addr1;
      sel_wdata_s = i_wdata1;
    end else begin
      sel_we_s    = i_we0;
      sel_addr_s  = i_addr0;
      sel_wdata_s = i_wdata0;
    end
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; a write finishes in ISSUE, a read needs the RDATA cycle.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_s) begin
          state_next_s = ISSUE;
        end else begin
          state_next_s = IDLE;
        end
      end
      ISSUE: begin
        if (load_r) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RDATA;
        end
      end
      RDATA:   state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Capture on grant, pulse ack/rvalid, and return read data to the winner.
  // RAM address/data only change on a capture, so they hold outside ISSUE.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      winner_r <= REQ_CPU;
      ack_r    <= 2'b00;
      rvalid_r <= 2'b00;
      load_r   <= 1'b0;
      addr_r   <= {ADDR_WIDTH{1'b0}};
      data_r   <= {DATA_WIDTH{1'b0}};
      rdata0_r <= {DATA_WIDTH{1'b0}};
      rdata1_r <= {DATA_WIDTH{1'b0}};
    end else begin
      ack_r    <= 2'b00;
      rvalid_r <= 2'b00;
      load_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (grant_s) begin
            winner_r <= winner_s;
            ack_r    <= grant_onehot(winner_s);
            load_r   <= sel_we_s;
            addr_r   <= sel_addr_s;
            data_r   <= sel_wdata_s;
          end
        end
        RDATA: begin
          rvalid_r <= grant_onehot(winner_r);
          if (winner_r == REQ_LOADER) begin
            rdata1_r <= i_ram_data;
          end else begin
            rdata0_r <= i_ram_data;
          end
        end
        default: begin
          ack_r <= 2'b00;
        end
      endcase
    end
  end

  assign o_ack0     = ack_r[0];
  assign o_ack1     = ack_r[1];
  assign o_rvalid0  = rvalid_r[0];
  assign o_rvalid1  = rvalid_r[1];
  assign o_rdata0   = rdata0_r;
  assign o_rdata1   = rdata1_r;
  assign o_ram_load = load_r;
  assign o_ram_addr = addr_r;
  assign o_ram_data = data_r;

endmodule
